// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
// Fetch front end for the multi-cycle core. Words come from a synchronous-read
// instruction memory and go into a small prefetch FIFO. Decode takes them from
// the FIFO with a valid/ready handshake, and each word carries its PC.
// A redirect flushes the FIFO and restarts fetch at a new address.
// Halt stops new requests, but the FIFO keeps draining to decode.
module instr_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fetchPc_q, fetchPc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflightPc_q, inflightPc_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] wordMem_q [DEPTH];
    logic [AW-1:0] pcMem_q   [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   pending;

    // Handshake, capture and issue decisions for the current cycle
    always_comb begin
        ir_valid = (count_q != '0);
        ir       = wordMem_q[rdPtr_q];
        ir_pc    = pcMem_q[rdPtr_q];
        pop      = ir_valid && ir_ready;
        // Memory latency is one cycle, so a killed response arrives on the
        // same edge as the redirect and is dropped there.
        push     = inflight_q && !redirect;
        // Count the slots already promised to stored or in-flight words.
        // A pop in this cycle frees one slot before the new word can arrive.
        pending  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        // While reset is held low, no request goes out.
        issue    = reset && !halt && !redirect && (pending < (CW+1)'(DEPTH));
        imem_en   = issue;
        imem_addr = fetchPc_q;
    end

    // Next-state for fetch PC, in-flight tracking and FIFO bookkeeping
    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = issue;
        inflightPc_d = inflightPc_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;

        if (issue) begin
            inflightPc_d = fetchPc_q;
        end

        if (redirect) begin
            // The flush also absorbs any pop in the same cycle.
            fetchPc_d = redirect_pc;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (issue) begin
                fetchPc_d = fetchPc_q + AW'(1);
            end
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers, cleared asynchronously when reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc_q    <= '0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage. It is cleared on reset so that ir and ir_pc read as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                wordMem_q[i] <= '0;
                pcMem_q[i]   <= '0;
            end
        end else if (push) begin
            wordMem_q[wrPtr_q] <= imem_rdata;
            pcMem_q[wrPtr_q]   <= inflightPc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer
// Drives directed phases and then random stimulus into instr_fetch_buffer.
// A transaction-level model checks every output in every cycle.
// The model is a queue of issued requests, each tagged with its issue cycle.
module tb_instr_fetch_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 16;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata = '0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halt = 1'b0;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready = 1'b0;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic [15:0] pc;
      int          cyc;
   } entry_t;

   entry_t      modelQ[$];
   logic [15:0] nextPc;
   int          cyc;

   instr_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .ir          (ir),
      .ir_pc       (ir_pc),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready)
   );

   // Free-running clock; rising edges fall at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Synchronous-read memory holding word = addr ^ 0xA5A5.
   // The data bus carries junk in cycles that follow no request.
   always @(posedge clk) begin
      if (imem_en)
         imem_rdata <= imem_addr ^ 16'hA5A5;
      else
         imem_rdata <= 16'($urandom);
   end

   // Counts a comparison and reports it if the values differ
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      nextPc = 16'h0000;
      cyc = 0;
   endtask

   // Pulls reset low between clock edges and checks that the outputs clear
   // at once. Reset stays low until the next applyStimulus call.
   task automatic doReset();
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async ir_valid", ir_valid, 0);
      checkOutput("async imem_en", imem_en, 0);
      halt = 1'b0;
      ir_ready = 1'b1;
      redirect = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst ir_valid", ir_valid, 0);
      checkOutput("rst imem_en", imem_en, 0);
      checkOutput("rst imem_addr", imem_addr, 0);
      checkOutput("rst ir", ir, 0);
      checkOutput("rst ir_pc", ir_pc, 0);
      modelReset();
   endtask

   // Runs one cycle: drives the inputs, compares every output with the
   // model, then advances the model across the rising edge
   task automatic applyStimulus(input logic h, input logic rdy, input logic redir, input logic [15:0] rpc);
      logic expValid;
      logic expPop;
      logic expEn;
      int   occ;
      @(negedge clk);
      reset = 1'b1;
      halt = h;
      ir_ready = rdy;
      redirect = redir;
      redirect_pc = rpc;
      #1;
      expValid = (modelQ.size() > 0) && (modelQ[0].cyc + 2 <= cyc);
      expPop = expValid && rdy;
      occ = modelQ.size() - (expPop ? 1 : 0);
      expEn = !h && !redir && (occ < DEPTH);
      checkOutput($sformatf("ir_valid@%0d", cyc), ir_valid, expValid);
      checkOutput($sformatf("imem_en@%0d", cyc), imem_en, expEn);
      if (expEn)
         checkOutput($sformatf("imem_addr@%0d", cyc), imem_addr, nextPc);
      if (expValid) begin
         checkOutput($sformatf("ir_pc@%0d", cyc), ir_pc, modelQ[0].pc);
         checkOutput($sformatf("ir@%0d", cyc), ir, modelQ[0].pc ^ 16'hA5A5);
      end
      if (redir) begin
         modelQ.delete();
         nextPc = rpc;
      end else begin
         if (expPop)
            void'(modelQ.pop_front());
         if (expEn) begin
            modelQ.push_back('{pc: nextPc, cyc: cyc});
            nextPc = nextPc + 16'h0001;
         end
      end
      cyc++;
   endtask

   // Directed phases from the test plan, then a long random run
   initial begin
      modelReset();
      doReset();

      repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100);
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0020);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      doReset();
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

      for (int i = 0; i < 3000; i++) begin
         logic        h;
         logic        rdy;
         logic        redir;
         logic [15:0] rpc;
         h = ($urandom_range(0, 9) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 31) == 0);
         rpc = 16'($urandom);
         applyStimulus(h, rdy, redir, rpc);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
